// File: rtl/inert_pkg.sv
// -----------------------------------------------------------------------------
// inert_pkg
// Shared types and constants for the inertial-sensor command sequencer.
//   state_t   : sequencer states (power-up, three config writes, idle, two reads)
//   *_CMD     : 16-bit SPI command words; bit 15 set marks a register read
//   is_cfg    : true for the config-write states
//   is_wait   : true for any state that is waiting on an SPI completion
// -----------------------------------------------------------------------------
package inert_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    CFG1,
    CFG2,
    CFG3,
    IDLE,
    RD_L,
    RD_H
  } state_t;

  localparam logic [15:0] CFG1_CMD = 16'h0D02;
  localparam logic [15:0] CFG2_CMD = 16'h1160;
  localparam logic [15:0] CFG3_CMD = 16'h1440;
  localparam logic [15:0] YAWL_CMD = 16'hA600;
  localparam logic [15:0] YAWH_CMD = 16'hA700;

  function automatic logic is_cfg(input state_t s);
    return (s == CFG1) || (s == CFG2) || (s == CFG3);
  endfunction

  function automatic logic is_wait(input state_t s);
    return is_cfg(s) || (s == RD_L) || (s == RD_H);
  endfunction

endpackage

// File: rtl/inert_seq_if.sv
// -----------------------------------------------------------------------------
// inert_seq_if
// Link between the command sequencer and the 16-bit SPI master.
//   wrt     : one-cycle pulse launching a transaction   (sequencer -> SPI)
//   cmd     : command word, held until completion       (sequencer -> SPI)
//   done    : completion level, cleared by SPI on wrt   (SPI -> sequencer)
//   rd_data : read data, low byte meaningful            (SPI -> sequencer)
// Modports: master = sequencer side, slave = SPI master side.
// -----------------------------------------------------------------------------
interface inert_seq_if;

  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;

  modport master (output wrt, output cmd, input done, input rd_data);
  modport slave  (input wrt, input cmd, output done, output rd_data);

endinterface

// File: rtl/inert_seq_int_sync.sv
// -----------------------------------------------------------------------------
// int_sync
// Two-flop synchronizer followed by a registered rising-edge detector.
// An input rise shows up on 'rise' three clocks later as a one-cycle pulse.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   async_in : asynchronous input level
//   rise     : one-cycle pulse on each synchronized 0->1 transition
// -----------------------------------------------------------------------------
module int_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;

  // NOTE: non-blocking assignments make every flop sample its pre-edge input;
  // blocking ones here would collapse the synchronizer chain into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/inert_seq.sv
// -----------------------------------------------------------------------------
// inert_seq
// Command sequencer upstream of a 16-bit SPI master. After a power-up settle
// time of 2^PWRUP_W clocks it issues three config writes, then answers each
// sensor data-ready edge by reading the yaw-rate low and high bytes.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   INT       : sensor data-ready, asynchronous to clk
//   spi       : inert_seq_if.master (wrt/cmd out, done/rd_data in)
//   yaw_rt    : signed yaw rate {high byte, low byte}
//   vld       : one-cycle pulse when yaw_rt is updated
//   init_done : high once all three config writes have completed
//   spi_err   : sticky SPI completion timeout flag
// Build option: define SPI_TMO_EN to enable the done timeout (TMO_CYC clocks).
// Without it the sequencer waits on done indefinitely and spi_err is 0.
// -----------------------------------------------------------------------------
module inert_seq
  import inert_pkg::*;
#(
  parameter int PWRUP_W = 16
`ifdef SPI_TMO_EN
  ,
  parameter int TMO_CYC = 1024
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  inert_seq_if.master spi,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        init_done,
  output logic        spi_err
);

  state_t             state_q;
  logic [PWRUP_W-1:0] timer_q;
  logic               done_q;
  logic               done_rise;
  logic               int_rise;
  logic               wrt_q;
  logic [15:0]        cmd_q;
  logic [7:0]         yaw_lo_q;
  logic [15:0]        yaw_q;
  logic               vld_q;
  logic               init_q;

`ifdef SPI_TMO_EN
  localparam int               TMO_W    = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  logic [TMO_W-1:0] tmo_q;
  logic             err_q;
`endif

  int_sync u_int_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (INT),
    .rise     (int_rise)
  );

  // Completion is an edge, not a level: done from the previous transaction
  // may still be high when the next one is launched.
  assign done_rise = spi.done & ~done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PWRUP;
      timer_q  <= '0;
      done_q   <= 1'b0;
      wrt_q    <= 1'b0;
      cmd_q    <= '0;
      yaw_lo_q <= '0;
      yaw_q    <= '0;
      vld_q    <= 1'b0;
      init_q   <= 1'b0;
`ifdef SPI_TMO_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      done_q <= spi.done;
      // Pulse outputs default low; each transition below raises them for a cycle.
      wrt_q  <= 1'b0;
      vld_q  <= 1'b0;

      unique case (state_q)
        PWRUP: begin
          timer_q <= timer_q + 1'b1;
          if (&timer_q) begin
            state_q <= CFG1;
            wrt_q   <= 1'b1;
            cmd_q   <= CFG1_CMD;
          end
        end
        CFG1: if (done_rise) begin
          state_q <= CFG2;
          wrt_q   <= 1'b1;
          cmd_q   <= CFG2_CMD;
        end
        CFG2: if (done_rise) begin
          state_q <= CFG3;
          wrt_q   <= 1'b1;
          cmd_q   <= CFG3_CMD;
        end
        CFG3: if (done_rise) begin
          state_q <= IDLE;
          init_q  <= 1'b1;
        end
        // Only the registered state is examined, so an edge arriving in the
        // same cycle IDLE is entered is dropped.
        IDLE: if (int_rise) begin
          state_q <= RD_L;
          wrt_q   <= 1'b1;
          cmd_q   <= YAWL_CMD;
        end
        RD_L: if (done_rise) begin
          yaw_lo_q <= spi.rd_data[7:0];
          state_q  <= RD_H;
          wrt_q    <= 1'b1;
          cmd_q    <= YAWH_CMD;
        end
        RD_H: if (done_rise) begin
          yaw_q   <= {spi.rd_data[7:0], yaw_lo_q};
          vld_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= PWRUP;
      endcase

`ifdef SPI_TMO_EN
      // Counter is zero on every launch because it is held clear outside
      // the waiting states and cleared again on each completion.
      if (is_wait(state_q) && !done_rise) begin
        if (tmo_q == TMO_LAST) begin
          err_q <= 1'b1;
          tmo_q <= '0;
          if (is_cfg(state_q)) begin
            state_q <= PWRUP;
            timer_q <= '0;
          end else begin
            state_q <= IDLE;
          end
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
      end
`endif
    end
  end

  assign spi.wrt   = wrt_q;
  assign spi.cmd   = cmd_q;
  assign yaw_rt    = yaw_q;
  assign vld       = vld_q;
  assign init_done = init_q;
`ifdef SPI_TMO_EN
  assign spi_err   = err_q;
`else
  assign spi_err   = 1'b0;
`endif

endmodule

// File: tb/tb_inert_seq.sv
// -----------------------------------------------------------------------------
// tb_inert_seq
// Directed bench for inert_seq with PWRUP_W=4 and a small SPI master model
// that raises done 40 clocks after it sees wrt. Outputs are sampled on the
// falling edge. With SPI_TMO_EN defined, TMO_CYC=64 and the timeout path runs.
// -----------------------------------------------------------------------------
module tb_inert_seq;

  localparam int SPI_DLY = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        INT = 1'b0;
  logic [15:0] yaw_rt;
  logic        vld;
  logic        init_done;
  logic        spi_err;

  inert_seq_if spi ();

  // SPI master model state
  logic        m_done   = 1'b0;
  logic [15:0] m_rd     = 16'h0000;
  int          m_cnt    = 0;
  logic        m_hold   = 1'b0;
  logic [15:0] m_cmd    = 16'h0000;
  logic        drop_rdl = 1'b0;
  logic [15:0] lo_word  = 16'h0000;
  logic [15:0] hi_word  = 16'h0000;

  int n_tests = 0;
  int n_fail  = 0;

  assign spi.done    = m_done;
  assign spi.rd_data = m_rd;

  always #5 clk = ~clk;

  inert_seq #(
    .PWRUP_W (4)
`ifdef SPI_TMO_EN
    ,
    .TMO_CYC (64)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .INT       (INT),
    .spi       (spi.master),
    .yaw_rt    (yaw_rt),
    .vld       (vld),
    .init_done (init_done),
    .spi_err   (spi_err)
  );

  // Not reset by rst: an in-flight transfer completes regardless.
  always @(posedge clk) begin
    if (spi.wrt) begin
      m_done <= 1'b0;
      m_cnt  <= SPI_DLY;
      m_cmd  <= spi.cmd;
      m_hold <= drop_rdl && (spi.cmd == 16'hA600);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !m_hold) begin
        m_done <= 1'b1;
        m_rd   <= (m_cmd == 16'hA600) ? lo_word :
                  (m_cmd == 16'hA700) ? hi_word : 16'h0000;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_wrt"},  32'(spi.wrt),   0);
    check({tag, "_cmd"},  32'(spi.cmd),   0);
    check({tag, "_yaw"},  32'(yaw_rt),    0);
    check({tag, "_vld"},  32'(vld),       0);
    check({tag, "_init"}, 32'(init_done), 0);
    check({tag, "_err"},  32'(spi_err),   0);
  endtask

  // Waits (bounded) for a wrt pulse; n = falling edges waited, 0 if none.
  task automatic wait_wrt(input string tag, input logic [15:0] exp_cmd, input int max,
                          output int n);
    n = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (spi.wrt) begin
        n = i;
        break;
      end
    end
    check({tag, "_seen"}, 32'(n != 0), 1);
    check({tag, "_cmd"},  32'(spi.cmd), 32'(exp_cmd));
  endtask

  // Waits (bounded) for a fresh 0->1 on done; cmd must still be held.
  task automatic wait_done_rise(input string tag, input logic [15:0] held_cmd);
    logic prev;
    logic seen;
    prev = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (spi.done && !prev) begin
        seen = 1'b1;
        break;
      end
      prev = spi.done;
    end
    check({tag, "_done"}, 32'(seen), 1);
    check({tag, "_held"}, 32'(spi.cmd), 32'(held_cmd));
  endtask

  task automatic next_cmd(input string tag, input logic [15:0] held, input logic [15:0] exp);
    wait_done_rise(tag, held);
    @(negedge clk);
    check({tag, "_wrt"}, 32'(spi.wrt), 1);
    check({tag, "_cmd"}, 32'(spi.cmd), 32'(exp));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(spi.wrt), 0);
  endtask

  task automatic no_wrt(input string tag, input int cycles);
    logic any;
    any = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (spi.wrt) any = 1'b1;
    end
    check(tag, 32'(any), 0);
  endtask

  // Called on the falling edge where rst was just released.
  task automatic do_init(input string tag);
    int n;
    wait_wrt({tag, "_cfg1"}, 16'h0D02, 40, n);
    check({tag, "_pwrup_lat"}, 32'(n), 16);
    @(negedge clk);
    check({tag, "_cfg1_pulse"}, 32'(spi.wrt), 0);
    next_cmd({tag, "_cfg2"}, 16'h0D02, 16'h1160);
    next_cmd({tag, "_cfg3"}, 16'h1160, 16'h1440);
    check({tag, "_init_lo"}, 32'(init_done), 0);
    wait_done_rise({tag, "_cfg3_end"}, 16'h1440);
    @(negedge clk);
    check({tag, "_init_hi"}, 32'(init_done), 1);
    check({tag, "_no_wrt"},  32'(spi.wrt),   0);
  endtask

  task automatic do_read(input string tag, input logic [15:0] lo, input logic [15:0] hi,
                         input logic [15:0] exp_yaw, input bit poke_rdh);
    int n;
    lo_word = lo;
    hi_word = hi;
    INT = 1'b0;
    repeat (4) @(negedge clk);
    INT = 1'b1;
    wait_wrt({tag, "_rdl"}, 16'hA600, 10, n);
    check({tag, "_int_lat"}, 32'(n), 4);
    @(negedge clk);
    check({tag, "_rdl_pulse"}, 32'(spi.wrt), 0);
    next_cmd({tag, "_rdh"}, 16'hA600, 16'hA700);
    if (poke_rdh) begin
      INT = 1'b0;
      repeat (3) @(negedge clk);
      INT = 1'b1;
    end
    wait_done_rise({tag, "_end"}, 16'hA700);
    @(negedge clk);
    check({tag, "_vld"}, 32'(vld), 1);
    check({tag, "_yaw"}, 32'(yaw_rt), 32'(exp_yaw));
    @(negedge clk);
    check({tag, "_vld_pulse"}, 32'(vld), 0);
  endtask

  initial begin
    int n;
    int sv;
    logic any_vld;

    repeat (3) @(negedge clk);
    check_reset("rst0");
    rst = 1'b0;
    do_init("init");

    // Second edge lands in RD_H and must be dropped.
    do_read("rd1", 16'h00CD, 16'h00AB, 16'hABCD, 1'b1);
    no_wrt("rd1_drop", 20);

    // Fresh pair, negative value, junk upper bytes ignored.
    do_read("rd2", 16'h5A01, 16'hA580, 16'h8001, 1'b0);
    sv = $signed(yaw_rt);
    check("rd2_signed", 32'(sv), 32'(-32767));
    no_wrt("int_held", 60);

    // Reset from IDLE clears the captured sample and init_done.
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst1");
    rst = 1'b0;

    // Reset 30 cycles into CFG2; its done then rises during the restarted
    // power-up wait and must not advance the sequence.
    wait_wrt("re_cfg1", 16'h0D02, 40, n);
    check("re_pwrup_lat", 32'(n), 16);
    next_cmd("re_cfg2", 16'h0D02, 16'h1160);
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_cfg2");
    rst = 1'b0;
    do_init("init2");
    do_read("rd3", 16'h0034, 16'h0012, 16'h1234, 1'b0);

`ifdef SPI_TMO_EN
    drop_rdl = 1'b1;
    INT = 1'b0;
    repeat (4) @(negedge clk);
    INT = 1'b1;
    wait_wrt("tmo_rdl", 16'hA600, 10, n);
    any_vld = 1'b0;
    for (int i = 1; i < 64; i++) begin
      @(negedge clk);
      if (vld) any_vld = 1'b1;
    end
    check("tmo_early", 32'(spi_err), 0);
    @(negedge clk);
    if (vld) any_vld = 1'b1;
    check("tmo_err",   32'(spi_err), 1);
    check("tmo_novld", 32'(any_vld), 0);
    check("tmo_yaw",   32'(yaw_rt),  32'h1234);
    drop_rdl = 1'b0;
    do_read("rd4", 16'h0077, 16'h0066, 16'h6677, 1'b0);
    check("tmo_sticky", 32'(spi_err), 1);
`else
    any_vld = 1'b0;
    check("no_tmo_err", 32'(spi_err | any_vld), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
